// File: rtl/channel_scan_ctrl.sv
// Round-robin channel scanner: presents each enabled channel for dwell+1 accepted cycles.
// Optional inter-channel blanking cycle selected by macro SCAN_BLANK_EN.
module channel_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ready,
  output logic [1:0]         sel,
  output logic               valid,
  output logic               wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1
`ifdef SCAN_BLANK_EN
    ,
    BLANK = 2'd2
`endif
  } state_t;

  state_t             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [1:0]         sel_n;
  logic               valid_n, wrap_n;
  logic [1:0]         nxt_ch, low_ch;
  logic               adv;

  // First set mask bit strictly after cur in circular order; cur itself if it is the only one.
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k < 5; k++) begin
      if (!found && m[cur + 2'(k)]) begin
        r     = cur + 2'(k);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign nxt_ch = next_ch(sel, mask);
  assign low_ch = next_ch(2'd3, mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 2'd0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      valid <= valid_n;
      wrap  <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    valid_n = valid;
    wrap_n  = 1'b0;
    adv     = 1'b0;

    if (!en || mask == 4'b0000) begin
      state_n = IDLE;
      cnt_n   = '0;
      sel_n   = 2'd0;
      valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SCAN;
          cnt_n   = '0;
          sel_n   = low_ch;
          valid_n = 1'b1;
        end
        SCAN: begin
          // A dropped mask bit forces an advance; >= covers a dwell lowered below the count.
          if (!mask[sel]) begin
            adv = 1'b1;
          end else if (ready) begin
            if (cnt >= dwell) adv = 1'b1;
            else              cnt_n = cnt + DWELL_W'(1);
          end
          if (adv) begin
            cnt_n  = '0;
            sel_n  = nxt_ch;
            wrap_n = (nxt_ch <= sel);
`ifdef SCAN_BLANK_EN
            state_n = BLANK;
            valid_n = 1'b0;
`else
            valid_n = 1'b1;
`endif
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          state_n = SCAN;
          cnt_n   = '0;
          valid_n = 1'b1;
        end
`endif
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          sel_n   = 2'd0;
          valid_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_scan_ctrl.sv
// Directed and randomized bench for channel_scan_ctrl against a channel-presentation model.
module tb_channel_scan_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [3:0]    mask;
  logic [DW-1:0] dwell;
  logic          ready;
  logic [1:0]    sel;
  logic          valid;
  logic          wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // model: whether scanning, channel shown, accepted cycles on it so far, blank pending
  bit m_on, m_blank, m_valid, m_wrap;
  int m_sel, m_acc;

  channel_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .mask(mask), .dwell(dwell),
    .ready(ready), .sel(sel), .valid(valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int after(input int s, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(s + k) % 4]) return (s + k) % 4;
    return s;
  endfunction

  task automatic model_clear();
    m_on = 0; m_blank = 0; m_valid = 0; m_wrap = 0; m_sel = 0; m_acc = 0;
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT, compare.
  task automatic step(input string tag);
    int ns;
    bit go;
    go = 0;
    if (!en || mask == 4'b0) begin
      model_clear();
    end else if (!m_on) begin
      m_on = 1; m_sel = after(3, mask); m_valid = 1; m_wrap = 0; m_acc = 0;
    end else if (m_blank) begin
      m_blank = 0; m_valid = 1; m_wrap = 0; m_acc = 0;
    end else begin
      m_wrap = 0;
      if (!mask[m_sel]) go = 1;
      else if (ready) begin
        m_acc = m_acc + 1;
        if (m_acc > int'(dwell)) go = 1;
      end
      if (go) begin
        ns = after(m_sel, mask);
        m_wrap = (ns <= m_sel);
        m_sel = ns;
        m_acc = 0;
`ifdef SCAN_BLANK_EN
        m_blank = 1; m_valid = 0;
`else
        m_valid = 1;
`endif
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".sel"},   32'(sel),   32'(m_sel));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
  endtask

  initial begin
    int run;
    int seen;
    int exp_sel31 [13];
    exp_sel31 = '{0,0,0,1,1,1,2,2,2,3,3,3,0};

    rst = 1; en = 0; mask = 0; dwell = 0; ready = 0;
    model_clear();
    #12;
    chk("reset.sel", 32'(sel), 0);
    chk("reset.valid", 32'(valid), 0);
    chk("reset.wrap", 32'(wrap), 0);
    @(negedge clk);
    rst = 0;
    step("idle");

    // sequence with full mask, dwell 2
    en = 1; mask = 4'hF; dwell = 2; ready = 1;
    for (int i = 0; i < 13; i++) begin
      step("seq31");
`ifndef SCAN_BLANK_EN
      chk("seq31.dsel", 32'(sel), 32'(exp_sel31[i]));
      chk("seq31.dwrap", 32'(wrap), 32'(i == 12));
`endif
    end
    en = 0; step("seq31.off");

    // alternating pair, dwell 0
    en = 1; mask = 4'b1010; dwell = 0;
    for (int i = 0; i < 6; i++) begin
      step("seq32");
`ifndef SCAN_BLANK_EN
      chk("seq32.dsel", 32'(sel), (i % 2 == 0) ? 1 : 3);
      chk("seq32.dwrap", 32'(wrap), 32'(i == 2 || i == 4));
`endif
    end
    en = 0; step("seq32.off");

    // stall on channel 2: 4 accepted + 5 stalled cycles
    en = 1; mask = 4'hF; dwell = 3; ready = 1;
    run = 0;
    while (!(valid && sel == 2) && run < 30) begin step("seq33.pre"); run++; end
    chk("seq33.reach", 32'(valid && sel == 2), 1);
    seen = 1;
    step("seq33.a");
    if (valid && sel == 2) seen++;
    ready = 0;
    for (int i = 0; i < 5; i++) begin
      step("seq33.stall");
      if (valid && sel == 2) seen++;
    end
    ready = 1;
    run = 0;
    while (sel == 2 && run < 20) begin
      step("seq33.post");
      if (valid && sel == 2) seen++;
      run++;
    end
    chk("seq33.hold", 32'(seen), 9);
    en = 0; step("seq33.off");

    // mask bit of current channel drops, then disable
    en = 1; mask = 4'b0110; dwell = 5; ready = 1;
    step("seq34.start");
    chk("seq34.sel1", 32'(sel), 1);
    step("seq34.b");
    ready = 0; mask = 4'b0100;
    step("seq34.drop");
    chk("seq34.sel2", 32'(sel), 2);
    en = 0;
    step("seq34.off");
    chk("seq34.vld0", 32'(valid), 0);
    ready = 1;

    // asynchronous reset while on channel 3
    en = 1; mask = 4'hF; dwell = 0;
    run = 0;
    while (!(valid && sel == 3) && run < 20) begin step("seq35.pre"); run++; end
    chk("seq35.reach", 32'(sel), 3);
    #2 rst = 1;
    #1;
    chk("seq35.async.sel", 32'(sel), 0);
    chk("seq35.async.valid", 32'(valid), 0);
    @(negedge clk);
    rst = 0; mask = 4'b1000;
    model_clear();
    step("seq35.restart");
    chk("seq35.sel3", 32'(sel), 3);

`ifdef SCAN_BLANK_EN
    en = 0; step("seq36.off");
    en = 1; mask = 4'b0011; dwell = 1; ready = 1;
    for (int i = 0; i < 6; i++) begin
      step("seq36");
      chk("seq36.dvalid", 32'(valid), 32'(i != 2 && i != 5));
      chk("seq36.dsel", 32'(sel), (i >= 2 && i <= 4) ? 1 : 0);
    end
`endif

    // randomized traffic including dwell/mask changes and disables
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 8)  mask  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 5)  dwell = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 999) < 3) dwell = DW'($urandom_range(200, 255));
      en    = ($urandom_range(0, 99) < 97);
      ready = ($urandom_range(0, 99) < 70);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/channel_scan_ctrl.md
CHANNEL_SCAN_CTRL -- requirements
Module: channel_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8: width of dwell count.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  scan enable; 1 = run, 0 = return to idle.
REQ-005 SHALL have port mask  input  4  channel enable mask; bit i = channel i participates.
REQ-006 SHALL have port dwell  input  DWELL_W  channel hold time minus one, in accepted cycles.
REQ-007 SHALL have port ready  input  1  downstream accept; dwell advances only when valid & ready.
REQ-008 SHALL have port sel  output  2  registered channel index; drives the 2-to-4 one-hot decoder select.
REQ-009 SHALL have port valid  output  1  registered; sel is meaningful.
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse on wrap-around from highest to lowest enabled channel.

Function
REQ-011 SHALL implement states IDLE, SCAN and, per REQ-030, BLANK.
REQ-012 SHALL stay in IDLE with sel=0, valid=0, wrap=0.
REQ-013 IDLE->SCAN SHALL occur on the first edge with en=1 and mask!=0; sel = lowest set bit of mask; valid=1 on that same edge; dwell counter = 0.
REQ-014 In SCAN, the counter SHALL increment on each edge with ready=1; ready=0 freezes the counter and holds sel/valid (stall).
REQ-015 On an edge with ready=1 and counter==dwell, sel SHALL advance to the next set mask bit in circular ascending order (i+1 ... 3, 0 ...), and the counter SHALL clear.
REQ-016 Channel i SHALL therefore be presented for exactly dwell+1 accepted cycles; dwell=0 advances every accepted cycle.
REQ-017 wrap SHALL be 1 for exactly the one cycle following an advance whose new index <= old index; otherwise 0.
REQ-018 With exactly one enabled channel, sel SHALL stay constant and wrap SHALL pulse at every dwell completion.
REQ-019 If mask bit of the current sel clears during SCAN, sel SHALL advance to the next enabled channel on the next edge regardless of ready or counter, and the counter SHALL clear; wrap follows REQ-017.
REQ-020 en=0 or mask=0 in any non-IDLE state SHALL force IDLE on the next edge (sel=0, valid=0, wrap=0, counter=0), overriding all other events.
REQ-021 Change of dwell mid-channel SHALL take effect on the compare immediately; if counter > new dwell, advance on the next accepted cycle.
REQ-022 Counter SHALL be DWELL_W bits and never wrap (it clears at dwell, which is <= 2^DWELL_W-1).
REQ-023 sel, valid and wrap SHALL be driven directly from flops; no combinational input-to-output paths.

Reset
REQ-024 Asserting rst SHALL immediately (asynchronously) force state=IDLE, sel=0, valid=0, wrap=0, counter=0.
REQ-025 Reset mid-scan SHALL discard position; after release, scan restarts per REQ-013 from lowest enabled channel.
REQ-026 First state change after release SHALL occur on the first rising clk edge with rst=0.

Configuration
REQ-027 Macro SCAN_BLANK_EN SHALL select inter-channel blanking.
REQ-028 Without SCAN_BLANK_EN: advances go SCAN->SCAN directly, with no gap in valid.
REQ-029 With SCAN_BLANK_EN: every advance (REQ-015, REQ-019) SHALL pass through BLANK for one cycle: sel = new index, valid=0, counter=0, ready ignored; then SCAN with valid=1.
REQ-030 BLANK SHALL exist only when SCAN_BLANK_EN is defined; REQ-020 and REQ-024 apply in BLANK; wrap pulse coincides with the BLANK cycle.

Verification
REQ-031 mask=4'b1111, dwell=2, ready=1, en=1 -> sel 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap=1 only during the first cycle of the second sel=0.
REQ-032 mask=4'b1010, dwell=0 -> sel alternates 1,3,1,3; wrap=1 on every cycle sel=1 after the first.
REQ-033 mask=4'b1111, dwell=3, ready low for 5 cycles mid-channel 2 -> sel=2 held for 4+5 cycles total; counter resumes from its frozen value.
REQ-034 Scanning at sel=1 with mask=4'b0110, then mask -> 4'b0100 -> next edge sel=2, counter=0; then en=0 -> next edge valid=0, sel=0.
REQ-035 rst pulsed between edges while sel=3 -> sel=0, valid=0 before next edge; after release with mask=4'b1000, sel=3 on first edge.
REQ-036 SCAN_BLANK_EN defined, mask=4'b0011, dwell=1 -> valid pattern 1,1,0,1,1,0; sel 0,0,1,1,1,0.
